// File: rtl/cv_loader_if.sv
// Memory read port and conv-core stream bundle between cv_loader and its neighbours.
interface cv_loader_if;
  localparam int unsigned AW = 26;
  localparam int unsigned RW = 32;
  localparam int unsigned DW = 16;

  logic          rvalid;
  logic [AW-1:0] raddr;
  logic          rready;
  logic [RW-1:0] rdata;
  logic          din_valid;
  logic [DW-1:0] din_data;

  modport master (
    output rvalid, raddr, din_valid, din_data,
    input  rready, rdata
  );

  modport slave (
    input  rvalid, raddr, din_valid, din_data,
    output rready, rdata
  );
endinterface

// File: rtl/cv_loader.sv
// Fetches the activation tensor then the weight tensor from word memory and streams
// each word's low half to the conv core, ending with a zero terminator. Option: CV_LOADER_PERF_EN.
module cv_loader #(
  parameter int unsigned GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [25:0] act_base,
  input  logic [25:0] wgt_base,
  input  logic [4:0]  H,
  input  logic [4:0]  W,
  input  logic [7:0]  I,
  input  logic [7:0]  O,
  input  logic [2:0]  K,
  cv_loader_if.master bus,
  output logic        busy,
  output logic        done
`ifdef CV_LOADER_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 16;
  localparam int unsigned GW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_REQ, S_EMIT, S_WAIT, S_TERM, S_DONE
  } state_t;

  state_t        state_q, state_d, tgt_c;
  logic [AW-1:0] act_base_q, wgt_base_q;
  logic [4:0]    h_q, w_q;
  logic [7:0]    i_q, o_q;
  logic [2:0]    k_q;
  logic [AW-1:0] na_q, nw_q, idx_q, idx_d;
  logic          is_wgt_q, is_wgt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rvalid_d, din_valid_d, busy_d, done_d;
  logic [AW-1:0] raddr_d;
  logic [DW-1:0] din_data_d;
  logic [AW-1:0] na_c, nw_c, cnt_c;
  logic          more_c;
  logic          unused_ok;

  assign unused_ok = &{1'b0, bus.rdata[31:16]};

  assign na_c  = AW'(i_q) * AW'(h_q) * AW'(w_q);
  assign nw_c  = AW'(o_q) * AW'(i_q) * AW'(k_q) * AW'(k_q);
  assign cnt_c = is_wgt_q ? nw_q : na_q;
  // idx counts words already accepted in the current phase
  assign more_c = (idx_q != cnt_c) || (!is_wgt_q && (nw_q != '0));
  assign tgt_c  = more_c ? S_REQ : S_TERM;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    is_wgt_d    = is_wgt_q;
    gap_d       = gap_q;
    rvalid_d    = 1'b0;
    raddr_d     = bus.raddr;
    din_valid_d = 1'b0;
    din_data_d  = bus.din_data;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: begin
        idx_d = '0;
        if (na_c != '0) begin
          is_wgt_d = 1'b0;
          state_d  = S_REQ;
        end else if (nw_c != '0) begin
          is_wgt_d = 1'b1;
          state_d  = S_REQ;
        end else begin
          state_d  = S_TERM;
        end
      end
      S_REQ: begin
        if (bus.rready) begin
          idx_d   = idx_q + AW'(1);
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // last activation word: switch to the weight phase before the gap
        if ((idx_q == cnt_c) && !is_wgt_q && (nw_q != '0)) begin
          is_wgt_d = 1'b1;
          idx_d    = '0;
        end
        gap_d   = '0;
        state_d = (GAP == 0) ? tgt_c : S_WAIT;
      end
      S_WAIT: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP - 1)) state_d = tgt_c;
      end
      S_TERM:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rvalid_d    = (state_d == S_REQ);
    din_valid_d = (state_d == S_EMIT) || (state_d == S_TERM);
    done_d      = (state_d == S_DONE);
    busy_d      = state_d inside {S_CALC, S_REQ, S_EMIT, S_WAIT, S_TERM};
    if ((state_d == S_REQ) && (state_q != S_REQ))
      raddr_d = (is_wgt_d ? wgt_base_q : act_base_q) + idx_d;
    if (state_d == S_TERM)
      din_data_d = '0;
    else if ((state_q == S_REQ) && bus.rready)
      din_data_d = bus.rdata[DW-1:0];
  end

  // Datapath, sampled configuration and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      act_base_q    <= '0;
      wgt_base_q    <= '0;
      h_q           <= '0;
      w_q           <= '0;
      i_q           <= '0;
      o_q           <= '0;
      k_q           <= '0;
      na_q          <= '0;
      nw_q          <= '0;
      idx_q         <= '0;
      is_wgt_q      <= 1'b0;
      gap_q         <= '0;
      bus.rvalid    <= 1'b0;
      bus.raddr     <= '0;
      bus.din_valid <= 1'b0;
      bus.din_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        act_base_q <= act_base;
        wgt_base_q <= wgt_base;
        h_q        <= H;
        w_q        <= W;
        i_q        <= I;
        o_q        <= O;
        k_q        <= K;
      end
      if (state_q == S_CALC) begin
        na_q <= na_c;
        nw_q <= nw_c;
      end
      idx_q         <= idx_d;
      is_wgt_q      <= is_wgt_d;
      gap_q         <= gap_d;
      bus.rvalid    <= rvalid_d;
      bus.raddr     <= raddr_d;
      bus.din_valid <= din_valid_d;
      bus.din_data  <= din_data_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

`ifdef CV_LOADER_PERF_EN
  // Saturating count of request cycles the memory left unanswered
  always_ff @(posedge clk) begin
    if (rst || ((state_q == S_IDLE) && start))
      stall_cnt <= '0;
    else if (bus.rvalid && !bus.rready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`else
  // stall counter not present in this build
`endif
endmodule

// File: doc/cv_loader.md
# cv_loader

Upstream feeder for the conv core: on `start` it fetches the activation tensor (I×H×W words) and then the weight tensor (O×I×K×K words) from word-addressed memory over the read port. It streams the low 16 bits of each word into the core's `din_valid`/`din_data` input in linear address order, then issues one terminator pulse. It replaces bench-driven stimulus in the system build and sits between the memory read port and the conv core.

## Interface
Parameters:
- `GAP`, 0, minimum idle cycles between consecutive `din_valid` pulses (0–15).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle launch pulse; ignored while `busy`.
- `act_base`  in  26  word address of activation element 0.
- `wgt_base`  in  26  word address of weight element 0.
- `H`, `W`  in  5 each  activation height/width.
- `I`, `O`  in  8 each  input/output channel counts.
- `K`  in  3  kernel size.
- `rvalid`  out  1  read request valid.
- `raddr`  out  26  read word address.
- `rready`  in  1  request accepted; `rdata` valid in the same cycle.
- `rdata`  in  32  read data.
- `din_valid`  out  1  one-cycle word strobe to the core.
- `din_data`  out  16  word to the core.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- Dimension inputs, `act_base`, and `wgt_base` are sampled on `start` and held internally; later changes are ignored until the next start.
- Counts: `NA = I*H*W` (max 245,055) and `NW = O*I*K*K` (max 3,186,225). Both are computed into 26-bit registers on the cycle after `start`; no overflow is possible.
- FSM states:
  - IDLE → CALC on `start`.
  - CALC → ACT (if NA>0), else WGT (if NW>0), else TERM.
  - ACT: read `act_base+idx` for idx = 0..NA−1. Then → WGT, or → TERM if NW=0.
  - WGT: read `wgt_base+idx` for idx = 0..NW−1. Then → TERM.
  - TERM: one `din_valid` pulse with `din_data`=16'h0000. Then → DONE.
  - DONE: `done`=1 for one cycle. Then → IDLE.
- Per-word sub-sequence in ACT and WGT:
  - REQ: hold `rvalid`=1 with a stable `raddr` until `rready`.
  - On `rready`, register `rdata[15:0]`.
  - EMIT: `din_valid`=1 for one cycle.
  - WAIT: GAP cycles.
  - Next REQ.
- Address arithmetic is modulo 2^26: base+idx wraps silently past 26'h3FFFFFF.
- `rdata[31:16]` is discarded. No sign handling.
- The core has no backpressure; `din_valid` pulses are never stalled once emitted.
- `rst` at any cycle, including mid-tensor or while a request is pending: next cycle is IDLE, all outputs at reset values, and the sampled configuration is discarded. The aborted request is dropped; memory must tolerate `rvalid` falling without `rready`.
- `start` while `busy`: ignored, no effect.
- `start` in the same cycle as `rst`: `rst` wins.

## Timing
- Reset values: `rvalid`=0, `raddr`=0, `din_valid`=0, `din_data`=0, `busy`=0, `done`=0.
- `start` at cycle T:
  - `busy`=1 at T+1 (CALC).
  - First `rvalid` at T+2.
- `rready` sampled high at cycle R:
  - `rvalid`=0 and `din_valid`=1 with the captured data at R+1.
  - Next `rvalid` at R+2+GAP.
- Throughput with zero-wait memory: one word per 2+GAP cycles.
- `raddr` is registered and changes only in the cycle `rvalid` rises.
- The terminator pulse occurs GAP+1 cycles after the last data pulse. With NA=NW=0 it occurs at T+2.
- `done` is asserted in the cycle after the terminator. `busy` falls in the same cycle `done` is high.
- `din_data` holds its last value when `din_valid`=0.

## Configuration
- `CV_LOADER_PERF_EN` defined:
  - Adds output `stall_cnt` (out, 32 bits): the number of cycles `rvalid`=1 && `rready`=0 since the last `start`.
  - The counter is cleared on `start` and on `rst`, and saturates at 32'hFFFFFFFF.
- Undefined: the port and its logic are absent. Functional behaviour is identical either way.

## Test plan
- H=W=2, I=1, O=1, K=1, GAP=0, zero-wait memory returning addr+16'h100 at act_base=0x10 and wgt_base=0x40:
  - 5 data pulses 0x110, 0x111, 0x112, 0x113, 0x140, each 2 cycles apart, then terminator 0x0000.
  - `done` 1 cycle after the terminator.
- Same config with GAP=5: data pulses spaced exactly 7 cycles apart.
- Memory inserts 3 wait cycles on every request:
  - `raddr` stable while `rvalid` is high.
  - Spacing 5 cycles.
  - With `CV_LOADER_PERF_EN`, `stall_cnt`=15 at `done`.
- I=0: ACT and WGT are skipped. Terminator at T+2, `done` at T+3, no `rvalid` ever.
- `rst` asserted while `rvalid` is pending in WGT:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A subsequent `start` replays from act_base.
- `start` pulsed again mid-ACT: ignored; pulse count and addresses unchanged.
- act_base=26'h3FFFFFE with NA=4: `raddr` sequence 3FFFFFE, 3FFFFFF, 0000000, 0000001.
